lsu_rmw: RTL and testbench

Load/store unit between the core's memory stage and the word-addressed data RAM (32-bit words, combinational read, write on clk rising edge when write-enabled).
- Converts byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw requests into RAM word accesses.
- Performs read-modify-write for sub-word stores.
- Sign- or zero-extends sub-word loads.
- Flags misaligned, out-of-range and illegal-size accesses without touching RAM.

---
 rtl/lsu_rmw_if.sv | 24 ++
 rtl/lsu_rmw.sv | 216 +++++++++++++++++++++
 tb/tb_lsu_rmw.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_rmw_if.sv
// Core-side request/response bundle of the load/store unit.
// master = memory stage of the core, slave = lsu_rmw.
interface lsu_rmw_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        busy;

  modport master (
    output req, wr, size, sext, addr, wdata,
    input  rdata, done, err, busy
  );

  modport slave (
    input  req, wr, size, sext, addr, wdata,
    output rdata, done, err, busy
  );
endinterface

// File: rtl/lsu_rmw.sv
// Load/store unit: byte-addressed core accesses onto a word RAM, with
// read-modify-write for sub-word stores and early rejection of bad accesses.

module lsu_rmw_chk (
  input logic clk,
  input logic rst_n,
  input logic done,
  input logic err,
  input logic ram_we
);
  a_err_with_done : assert property (@(posedge clk) disable iff (!rst_n) err |-> done);
  a_done_pulse    : assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);
  a_we_pulse      : assert property (@(posedge clk) disable iff (!rst_n) ram_we |=> !ram_we);
  a_we_not_done   : assert property (@(posedge clk) disable iff (!rst_n) ram_we |-> !done);
endmodule

module lsu_rmw #(
  parameter int DEPTH_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  lsu_rmw_if.slave    core,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_d_in,
  input  logic [31:0] ram_d_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ERR    = 2'b01,
    ACCESS = 2'b10,
    WRITE  = 2'b11
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        wr_r;
  logic [1:0]  size_r;
  logic        sext_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] merge_r;
  logic [31:0] rdata_r;
  logic        done_r;
  logic        err_r;

  logic        align_bad_s;
  logic        range_bad_s;
  logic        req_bad_s;
  logic        accept_s;
  logic        done_set_s;
  logic        err_set_s;
  logic        rdata_ld_s;
  logic        merge_ld_s;

  // Little-endian lane pick with optional sign extension; words pass through.
  function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                               input logic [1:0]  sz,
                                               input logic [1:0]  off,
                                               input logic        sx);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   res = {{24{sx & b[7]}}, b};
      2'b01:   res = {{16{sx & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [1:0]  sz,
                                             input logic [1:0]  off,
                                             input logic [31:0] data);
    logic [31:0] res;
    res = word;
    case (sz)
      2'b00: res[{off, 3'b000} +: 8] = data[7:0];
      2'b01: begin
        if (off[1]) begin
          res[31:16] = data[15:0];
        end else begin
          res[15:0] = data[15:0];
        end
      end
      default: res = data;
    endcase
    return res;
  endfunction

  // Acceptance-time legality check on the raw request.
  always_comb begin
    align_bad_s = 1'b0;
    case (core.size)
      2'b00:   align_bad_s = 1'b0;
      2'b01:   align_bad_s = core.addr[0];
      2'b10:   align_bad_s = |core.addr[1:0];
      default: align_bad_s = 1'b1;
    endcase
    range_bad_s = ({2'b00, core.addr[31:2]} >= 32'(DEPTH_WORDS));
    req_bad_s   = align_bad_s | range_bad_s;
  end

  // Next-state and per-state RAM/strobe decode.
  always_comb begin
    state_nxt_s = state_r;
    ram_we      = 1'b0;
    accept_s    = 1'b0;
    done_set_s  = 1'b0;
    err_set_s   = 1'b0;
    rdata_ld_s  = 1'b0;
    merge_ld_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (core.req) begin
          accept_s    = 1'b1;
          state_nxt_s = req_bad_s ? ERR : ACCESS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ERR: begin
        done_set_s  = 1'b1;
        err_set_s   = 1'b1;
        state_nxt_s = IDLE;
      end
      ACCESS: begin
        if (!wr_r) begin
          rdata_ld_s  = 1'b1;
          done_set_s  = 1'b1;
          state_nxt_s = IDLE;
        end else if (size_r == 2'b10) begin
          ram_we      = 1'b1;
          done_set_s  = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          merge_ld_s  = 1'b1;
          state_nxt_s = WRITE;
        end
      end
      WRITE: begin
        ram_we      = 1'b1;
        done_set_s  = 1'b1;
        state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request latch and merged write word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_r    <= 1'b0;
      size_r  <= 2'b00;
      sext_r  <= 1'b0;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      merge_r <= 32'h0000_0000;
    end else begin
      if (accept_s) begin
        wr_r    <= core.wr;
        size_r  <= core.size;
        sext_r  <= core.sext;
        addr_r  <= core.addr;
        wdata_r <= core.wdata;
      end
      if (merge_ld_s) begin
        merge_r <= merge_lane(ram_d_out, size_r, addr_r[1:0], wdata_r);
      end
    end
  end

  // Registered core-side response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= 32'h0000_0000;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      done_r <= done_set_s;
      err_r  <= err_set_s;
      if (rdata_ld_s) begin
        rdata_r <= extract_lane(ram_d_out, size_r, addr_r[1:0], sext_r);
      end
    end
  end

  assign ram_addr   = {2'b00, addr_r[31:2]};
  assign ram_d_in   = (state_r == WRITE) ? merge_r : wdata_r;
  assign core.rdata = rdata_r;
  assign core.done  = done_r;
  assign core.err   = err_r;
  assign core.busy  = (state_r != IDLE);

  lsu_rmw_chk u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .done   (done_r),
    .err    (err_r),
    .ram_we (ram_we)
  );

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw: stimulus pushes expected responses into a
// scoreboard queue; a negedge monitor pops and compares on every done pulse.
module tb_lsu_rmw;
  logic        clk;
  logic        rst_n;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_d_in;
  logic [31:0] ram_d_out;

  lsu_rmw_if core_bus ();

  lsu_rmw #(.DEPTH_WORDS(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .core      (core_bus),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_d_in  (ram_d_in),
    .ram_d_out (ram_d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural word RAM with a bench-side preload port.
  logic [31:0] mem [32];
  logic        poke_en;
  logic [4:0]  poke_a;
  logic [31:0] poke_d;

  assign ram_d_out = (ram_addr < 32'd32) ? mem[ram_addr[4:0]] : 32'h0000_0000;

  always @(posedge clk) begin
    if (poke_en) mem[poke_a] <= poke_d;
    else if (ram_we && ram_addr < 32'd32) mem[ram_addr[4:0]] <= ram_d_in;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          we_n;
    logic [31:0] we_data;
    logic [31:0] we_addr;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] last_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: tracks busy cycles and RAM writes, checks them at each done.
  int          mon_lat = 0;
  int          mon_we_n = 0;
  logic [31:0] mon_we_d;
  logic [31:0] mon_we_a;
  exp_t        e;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_lat  = 0;
      mon_we_n = 0;
    end else begin
      if (core_bus.err && !core_bus.done) chk("err_without_done", 32'd1, 32'd0);
      if (ram_we) begin
        mon_we_n++;
        mon_we_d = ram_d_in;
        mon_we_a = ram_addr;
      end
      if (core_bus.busy) mon_lat++;
      if (core_bus.done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("rdata", core_bus.rdata, e.rdata);
          chk("err", {31'd0, core_bus.err}, {31'd0, e.err});
          chk("busy_cycles", mon_lat, e.lat);
          chk("ram_we_cycles", mon_we_n, e.we_n);
          if (e.we_n == 1 && mon_we_n == 1) begin
            chk("ram_d_in", mon_we_d, e.we_data);
            chk("ram_addr", mon_we_a, e.we_addr);
          end
        end
        mon_lat  = 0;
        mon_we_n = 0;
      end
    end
  end

  task automatic poke(input int a, input logic [31:0] d);
    poke_a  = a[4:0];
    poke_d  = d;
    poke_en = 1'b1;
    @(posedge clk);
    #1 poke_en = 1'b0;
    @(negedge clk);
  endtask

  // Issue one request (called at a negedge) and wait for its done pulse.
  task automatic do_op(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int exp_we, input logic [31:0] exp_wd, input int exp_lat);
    exp_t x;
    bit   seen;
    x.rdata   = exp_rd;
    x.err     = exp_err;
    x.we_n    = exp_we;
    x.we_data = exp_wd;
    x.we_addr = {2'b00, a[31:2]};
    x.lat     = exp_lat;
    sb_q.push_back(x);
    last_rdata = exp_rd;
    core_bus.req   = 1'b1;
    core_bus.wr    = w;
    core_bus.size  = sz;
    core_bus.sext  = sx;
    core_bus.addr  = a;
    core_bus.wdata = wd;
    @(posedge clk);
    #1 core_bus.req = 1'b0;
    core_bus.wdata = 32'h5A5A_5A5A;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (core_bus.done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic ld(input logic [1:0] sz, input logic sx, input logic [31:0] a,
                    input logic [31:0] exp_rd);
    do_op(1'b0, sz, sx, a, 32'h0, exp_rd, 1'b0, 0, 32'h0, 1);
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                    input logic [31:0] merged);
    do_op(1'b1, sz, 1'b0, a, wd, last_rdata, 1'b0, 1, merged, (sz == 2'b10) ? 1 : 2);
  endtask

  task automatic bad(input logic w, input logic [1:0] sz, input logic [31:0] a);
    do_op(w, sz, 1'b0, a, 32'hDEAD_BEEF, last_rdata, 1'b1, 0, 32'h0, 1);
  endtask

  initial begin
    poke_en = 1'b0; poke_a = 5'd0; poke_d = 32'h0;
    core_bus.req = 1'b0; core_bus.wr = 1'b0; core_bus.size = 2'b00;
    core_bus.sext = 1'b0; core_bus.addr = 32'h0; core_bus.wdata = 32'h0;
    last_rdata = 32'h0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rdata", core_bus.rdata, 32'h0);
    chk("reset_done", {31'd0, core_bus.done}, 32'd0);
    chk("reset_busy", {31'd0, core_bus.busy}, 32'd0);
    chk("reset_we", {31'd0, ram_we}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    poke(1, 32'h1000_0002);
    poke(2, 32'h0000_0004);
    poke(30, 32'hFFFF_FFF3);
    poke(31, 32'h8000_0000);

    ld(2'b10, 1'b0, 32'h04, 32'h1000_0002);
    ld(2'b00, 1'b1, 32'h78, 32'hFFFF_FFF3);
    ld(2'b00, 1'b0, 32'h78, 32'h0000_00F3);
    ld(2'b01, 1'b1, 32'h7A, 32'hFFFF_FFFF);
    ld(2'b01, 1'b0, 32'h7A, 32'h0000_FFFF);
    ld(2'b00, 1'b0, 32'h79, 32'h0000_00FF);
    ld(2'b00, 1'b1, 32'h7F, 32'hFFFF_FF80);
    ld(2'b10, 1'b1, 32'h7C, 32'h8000_0000);

    st(2'b00, 32'h09, 32'h0000_00AB, 32'h0000_AB04);
    ld(2'b10, 1'b0, 32'h08, 32'h0000_AB04);
    st(2'b00, 32'h0B, 32'h1234_56C3, 32'hC300_AB04);
    ld(2'b10, 1'b0, 32'h08, 32'hC300_AB04);
    st(2'b01, 32'h06, 32'h0000_1234, 32'h1234_0002);
    ld(2'b10, 1'b0, 32'h04, 32'h1234_0002);
    st(2'b10, 32'h04, 32'hCAFE_F00D, 32'hCAFE_F00D);
    ld(2'b10, 1'b0, 32'h04, 32'hCAFE_F00D);
    st(2'b01, 32'h04, 32'h7777_BEEF, 32'hCAFE_BEEF);
    ld(2'b01, 1'b1, 32'h04, 32'hFFFF_BEEF);

    bad(1'b0, 2'b10, 32'h06);
    bad(1'b1, 2'b01, 32'h05);
    bad(1'b0, 2'b11, 32'h00);
    bad(1'b0, 2'b10, 32'h80);
    bad(1'b1, 2'b00, 32'h80);
    ld(2'b10, 1'b0, 32'h04, 32'hCAFE_BEEF);

    // Abort a sub-word store while its write is pending.
    poke(2, 32'h0000_0004);
    core_bus.req = 1'b1; core_bus.wr = 1'b1; core_bus.size = 2'b00;
    core_bus.sext = 1'b0; core_bus.addr = 32'h09; core_bus.wdata = 32'h0000_00AB;
    @(posedge clk);
    #1 core_bus.req = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_we_before", {31'd0, ram_we}, 32'd1);
    chk("abort_d_in", ram_d_in, 32'h0000_AB04);
    rst_n = 1'b0;
    #1;
    chk("abort_we_after", {31'd0, ram_we}, 32'd0);
    chk("abort_busy", {31'd0, core_bus.busy}, 32'd0);
    chk("abort_done", {31'd0, core_bus.done}, 32'd0);
    chk("abort_err", {31'd0, core_bus.err}, 32'd0);
    chk("abort_rdata", core_bus.rdata, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_mem", mem[2], 32'h0000_0004);
    rst_n = 1'b1;
    last_rdata = 32'h0;
    @(negedge clk);
    ld(2'b10, 1'b0, 32'h08, 32'h0000_0004);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
